serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits, SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1: bits processed per clock, SHALL divide WIDTH exactly; NSTEP = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block accepts an operand set.
REQ-007 a  input  WIDTH  minuend / first addend.
REQ-008 b  input  WIDTH  subtrahend / second addend.
REQ-009 mode  input  1  0 = add (a+b+c_in), 1 = subtract (a-b-c_in).
REQ-010 c_in  input  1  carry-in (add) or borrow-in (subtract).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 c_out  output  1  carry-out (add) or borrow-out (subtract).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  result equals 0.

Function
REQ-017 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE: on in_valid & in_ready at an edge, a, b, mode, c_in SHALL be captured, step counter cleared, state -> RUN.
REQ-019 RUN: each edge SHALL process the DIGIT least-significant unprocessed bits through a ripple of DIGIT full add/sub cells, propagating carry/borrow between cycles in a 1-bit register.
REQ-020 RUN -> DONE on the edge completing step NSTEP-1; out_valid SHALL rise exactly NSTEP edges after the accept edge.
REQ-021 Subtract SHALL compute a - b - c_in; c_out = 1 iff a < b + c_in (unsigned).
REQ-022 ovf SHALL be 1 when operand sign bits (b inverted for subtract) agree and result sign differs.
REQ-023 DONE: result, c_out, ovf, zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 DONE with out_ready=1 at an edge SHALL return to IDLE; no new operand is accepted on that same edge.
REQ-025 in_valid, a, b, mode, c_in SHALL be ignored in RUN and DONE.
REQ-026 result and flags SHALL hold their last values in IDLE until the next completion.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0, c_out=0, ovf=0, zero=0, counter and carry register 0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation; no partial result is ever presented.

Structure
REQ-029 Package serial_addsub_pkg SHALL hold the state enum and constants MODE_ADD=0, MODE_SUB=1.
REQ-030 Sub-module addsub_slice (combinational, DIGIT-bit ripple of full add/sub cells, carry-in/out, mode) SHALL be instantiated once.

Verification (WIDTH=8 unless stated)
REQ-031 add 8'h3C+8'h05, c_in=0 -> result 8'h41, c_out 0, ovf 0, zero 0, out_valid exactly 8 edges after accept.
REQ-032 add 8'hFF+8'h01 -> 8'h00, c_out 1, zero 1, ovf 0; add 8'h7F+8'h01 -> 8'h80, ovf 1, c_out 0.
REQ-033 sub 8'h05-8'h07, c_in=0 -> 8'hFE, c_out 1, ovf 0; sub 8'h80-8'h01 -> 8'h7F, ovf 1, c_out 0.
REQ-034 out_ready held 0 for 5 cycles in DONE with in_valid=1 and changing a/b -> outputs stable, in_ready 0, no capture; out_ready=1 -> IDLE next edge.
REQ-035 rst_n pulsed low during 3rd RUN cycle -> outputs clear without a clock edge, in_ready 1 after release, next operation correct.
REQ-036 DIGIT=4: sub 8'h10-8'h01, c_in=1 -> 8'h0E, c_out 0, out_valid 2 edges after accept.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared definitions for the digit-serial adder/subtractor:
//   FSM state encoding, operation mode constants and a helper that
//   sizes the step counter.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Counter width for n steps; at least one bit so a single-step
  // configuration still has a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Operand/result handshake bundle for serial_addsub.
//   Request side : in_valid/in_ready, a, b, mode, c_in
//   Response side: out_valid/out_ready, result, c_out, ovf, zero
//   master = producer of operands / consumer of results, slave = the block.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, mode, c_in, out_ready,
    input  in_ready, out_valid, result, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, mode, c_in, out_ready,
    output in_ready, out_valid, result, c_out, ovf, zero
  );
endinterface

// File: rtl/addsub_slice.sv
// addsub_slice
//   Combinational ripple of DIGIT full add/subtract cells.
//   i_a, i_b : operand digits (LSB first in the ripple)
//   i_mode   : MODE_ADD -> a+b+c, MODE_SUB -> a-b-c
//   i_cin    : carry-in (add) / borrow-in (subtract)
//   o_sum    : sum / difference digit
//   o_cout   : carry-out (add) / borrow-out (subtract)
module addsub_slice
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_mode,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
      logic w_p;
      assign w_p          = i_a[gi] ^ i_b[gi];
      assign o_sum[gi]    = w_p ^ w_c[gi];
      // Borrow chain for subtract, carry chain for add; the difference
      // bit is the same XOR as the sum bit.
      assign w_c[gi + 1]  = (i_mode == MODE_SUB)
                          ? ((~i_a[gi] & i_b[gi]) | (~w_p & w_c[gi]))
                          : (( i_a[gi] & i_b[gi]) | ( w_p & w_c[gi]));
    end
  endgenerate

  assign o_cout = w_c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT
//   clocks per operation, carry/borrow kept in a 1-bit register between
//   steps.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_if slave (operand handshake, result handshake,
//           result, c_out, ovf, zero)
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_addsub_if.slave    bus
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NSTEP);

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_mode;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_a;
  logic               r_sign_b;

  logic [WIDTH-1:0]   r_result;
  logic               r_c_out;
  logic               r_ovf;
  logic               r_zero;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;
  logic [DIGIT-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]   w_acc_next;

  addsub_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_mode (r_mode),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // New digits enter at the top of the accumulator; after NSTEP shifts
  // the first digit computed has reached bit 0.
  assign w_cat      = {w_sum, r_acc};
  assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_last   = (r_cnt == CNT_W'(NSTEP - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath. Output registers only change on the final step, so a
  // partially computed value is never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mode   <= MODE_ADD;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_result <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_mode   <= bus.mode;
            r_carry  <= bus.c_in;
            r_cnt    <= '0;
            // Effective sign of the second operand (inverted for subtract)
            r_sign_a <= bus.a[WIDTH-1];
            r_sign_b <= bus.b[WIDTH-1] ^ (bus.mode == MODE_SUB);
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_acc_next;
            r_c_out  <= w_cout;
            r_ovf    <= (r_sign_a == r_sign_b) &&
                        (w_acc_next[WIDTH-1] != r_sign_a);
            r_zero   <= (w_acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.c_out     = r_c_out;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  exp_t sb[$];

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(8)) bus4 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: 9-bit arithmetic, sign rule on operand bits.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic m, input logic ci);
    exp_t e;
    logic [8:0] full;
    logic [7:0] beff;
    if (m) full = {1'b0, a} - {1'b0, b} - {8'd0, ci};
    else   full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    beff  = m ? ~b : b;
    e.res = full[7:0];
    e.c   = full[8];
    e.v   = (a[7] == beff[7]) && (full[7] != a[7]);
    e.z   = (full[7:0] == 8'd0);
    return e;
  endfunction

  function automatic logic get_ready(input bit sel);
    return sel ? bus4.in_ready : bus8.in_ready;
  endfunction

  function automatic logic get_valid(input bit sel);
    return sel ? bus4.out_valid : bus8.out_valid;
  endfunction

  function automatic exp_t get_out(input bit sel);
    exp_t o;
    o.res = sel ? bus4.result : bus8.result;
    o.c   = sel ? bus4.c_out  : bus8.c_out;
    o.v   = sel ? bus4.ovf    : bus8.ovf;
    o.z   = sel ? bus4.zero   : bus8.zero;
    return o;
  endfunction

  task automatic drive_in(input bit sel, input logic v, input logic [7:0] a,
                          input logic [7:0] b, input logic m, input logic ci);
    if (sel) begin
      bus4.in_valid = v; bus4.a = a; bus4.b = b; bus4.mode = m; bus4.c_in = ci;
    end else begin
      bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.mode = m; bus8.c_in = ci;
    end
  endtask

  task automatic set_oready(input bit sel, input logic r);
    if (sel) bus4.out_ready = r;
    else     bus8.out_ready = r;
  endtask

  // Offer operands and pass the accept edge; expectation goes to the scoreboard.
  task automatic start_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic m, input logic ci, input string tag);
    check({tag, ".in_ready"}, 32'(get_ready(sel)), 32'd1);
    sb.push_back(model(a, b, m, ci));
    drive_in(sel, 1'b1, a, b, m, ci);
    @(posedge clk); #1;
    drive_in(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic wait_done(input bit sel, input int lat, input string tag);
    int n = 0;
    while (!get_valid(sel) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
  endtask

  task automatic check_out(input bit sel, input string tag);
    exp_t e;
    exp_t o;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    o = get_out(sel);
    check({tag, ".result"}, 32'(o.res), 32'(e.res));
    check({tag, ".c_out"},  32'(o.c),   32'(e.c));
    check({tag, ".ovf"},    32'(o.v),   32'(e.v));
    check({tag, ".zero"},   32'(o.z),   32'(e.z));
    $display("txn %s: result=%02h c_out=%0b ovf=%0b zero=%0b (exp %02h %0b %0b %0b)",
             tag, o.res, o.c, o.v, o.z, e.res, e.c, e.v, e.z);
  endtask

  task automatic release_out(input bit sel, input string tag);
    set_oready(sel, 1'b1);
    @(posedge clk); #1;
    set_oready(sel, 1'b0);
    check({tag, ".idle_ready"}, 32'(get_ready(sel)), 32'd1);
    check({tag, ".idle_valid"}, 32'(get_valid(sel)), 32'd0);
  endtask

  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic ci, input int lat, input string tag);
    start_op(sel, a, b, m, ci, tag);
    wait_done(sel, lat, tag);
    check_out(sel, tag);
    release_out(sel, tag);
  endtask

  initial begin
    exp_t held;
    exp_t o;
    rst_n = 1'b0;
    drive_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    set_oready(1'b0, 1'b0);
    set_oready(1'b1, 1'b0);
    #1;
    check("reset.in_ready",  32'(bus8.in_ready),  32'd1);
    check("reset.out_valid", 32'(bus8.out_valid), 32'd0);
    check("reset.outs", 32'(get_out(1'b0)), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 8'h3C, 8'h05, 1'b0, 1'b0, 8, "add_3c_05");
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, "add_ff_01");
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 8, "add_7f_01");
    run_op(1'b0, 8'h05, 8'h07, 1'b1, 1'b0, 8, "sub_05_07");
    run_op(1'b0, 8'h80, 8'h01, 1'b1, 1'b0, 8, "sub_80_01");
    run_op(1'b0, 8'hA5, 8'h5A, 1'b0, 1'b1, 8, "add_a5_5a_ci");
    run_op(1'b0, 8'h20, 8'h20, 1'b1, 1'b1, 8, "sub_20_20_bi");

    // Back-pressure in DONE with a busy, changing input side.
    start_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b1, "stall");
    wait_done(1'b0, 8, "stall");
    held = sb[0];
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      o = get_out(1'b0);
      check("stall.outs_stable", 32'(o), 32'(held));
      check("stall.in_ready",    32'(bus8.in_ready),  32'd0);
      check("stall.out_valid",   32'(bus8.out_valid), 32'd1);
    end
    check_out(1'b0, "stall");
    release_out(1'b0, "stall");
    drive_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("stall.no_capture", 32'(bus8.in_ready), 32'd1);
    check("stall.idle_hold",  32'(get_out(1'b0)), 32'(held));

    // Reset pulse in the third RUN cycle.
    start_op(1'b0, 8'h11, 8'h22, 1'b0, 1'b0, "rst_abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_abort.in_ready",  32'(bus8.in_ready),  32'd1);
    check("rst_abort.out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_abort.outs",      32'(get_out(1'b0)),  32'd0);
    void'(sb.pop_front());
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_abort.post_ready", 32'(bus8.in_ready),  32'd1);
    check("rst_abort.post_valid", 32'(bus8.out_valid), 32'd0);
    run_op(1'b0, 8'h3C, 8'h05, 1'b0, 1'b0, 8, "after_rst");

    // Four bits per clock.
    run_op(1'b1, 8'h10, 8'h01, 1'b1, 1'b1, 2, "d4_sub_10_01");
    run_op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 2, "d4_add_7f_01");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
